// File: rtl/lc_pkg.sv
// rtl/lc_pkg.sv - shared state type and line constants for serial_frame_tx
package lc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - BIT_CYCLES down-counter with a tick on the last cycle of each bit
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

  logic [7:0] cnt;

  // Wraps to LAST on its own at every bit end, so the FSM never has to reload mid-frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 8'd0;
    end else if (reload || cnt == 8'd0) begin
      cnt <= LAST;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tick = (cnt == 8'd0);

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - start/data/stop serial framer; even parity with SERIAL_FRAME_TX_PARITY_EN
module serial_frame_tx
  import lc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  localparam logic [4:0] LAST_IDX = 5'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [4:0]        bit_idx;
  logic              tick;
  logic              reload;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic              par_bit;
`endif

  // Holding the timer in reload while idle makes the START bit begin a full period.
  assign reload = (state == IDLE);

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk   (clk),
    .rst   (rst),
    .reload(reload),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= 5'd0;
      sout    <= LINE_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= din;
            bit_idx <= 5'd0;
            sout    <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_bit <= ^din;
`endif
          end
        end
        START: begin
          if (tick) begin
            sout  <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_IDX) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
              sout  <= par_bit;
              state <= PARITY;
`else
              sout  <= LINE_IDLE;
              state <= STOP;
`endif
            end else begin
              sout    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 5'd1;
            end
          end
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            sout  <= LINE_IDLE;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            sout  <= LINE_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          sout  <= LINE_IDLE;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits, legal range 1..16.
REQ-002 Parameter BIT_CYCLES, default 4: clk cycles per serial bit, legal range 1..255.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  frame request, sampled on the rising edge of clk.
REQ-006 Port din  input  DATA_W  payload, captured when a start is accepted.
REQ-007 Port sout  output  1  registered serial line; high when idle.
REQ-008 Port busy  output  1  high while a frame is in progress.
REQ-009 Port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY is reachable only when PARITY_EN is defined.
REQ-011 In IDLE, start=1 with busy=0 SHALL capture din into a shift register and enter START on the same edge.
REQ-012 sout SHALL be 0 and busy SHALL be 1 from the edge that accepts start, which gives one cycle of latency from start to line activity.
REQ-013 Each serial bit SHALL hold for exactly BIT_CYCLES cycles, timed by a cycle counter that reloads at every bit boundary.
REQ-014 DATA SHALL send DATA_W bits LSB first, tracked by a bit index running from 0 to DATA_W-1.
REQ-015 PARITY, when present, SHALL send the even-parity bit, which is the XOR of the captured payload.
REQ-016 STOP SHALL drive sout=1 for BIT_CYCLES cycles and then return to IDLE.
REQ-017 done SHALL be 1 for exactly the first IDLE cycle after STOP; busy SHALL be 0 in that cycle.
REQ-018 Frame length SHALL be (DATA_W+2)*BIT_CYCLES cycles without parity and (DATA_W+3)*BIT_CYCLES cycles with parity.
REQ-019 start while busy=1 SHALL be ignored, and the captured payload SHALL NOT change.
REQ-020 start=1 in the done cycle SHALL be accepted, so back-to-back frames are separated by exactly one idle cycle with sout=1.
REQ-021 din changes after capture SHALL NOT affect the frame in flight.
REQ-022 BIT_CYCLES=1 SHALL yield one cycle per bit with no cycle skipped or duplicated.

Reset
REQ-023 rst=0 SHALL immediately force state=IDLE, sout=1, busy=0 and done=0, and clear the counters and the shift register.
REQ-024 Reset mid-frame SHALL abort the frame with no done pulse; after rst rises, a new start is required.
REQ-025 start sampled on the first edge after rst rises SHALL be accepted normally.

Configuration
REQ-026 Macro SERIAL_FRAME_TX_PARITY_EN: when defined, the PARITY state and its even-parity bit SHALL be compiled in between DATA and STOP.
REQ-027 Without SERIAL_FRAME_TX_PARITY_EN, DATA SHALL go directly to STOP and no parity logic SHALL exist.

Structure
REQ-028 The shared package lc_pkg SHALL hold the state enum type tx_state_t and the idle-line constant LINE_IDLE=1'b1.
REQ-029 A single sub-module bit_timer SHALL contain the BIT_CYCLES down-counter, with ports clk, rst and reload, and a one-cycle output tick at each bit end.

Verification (DATA_W=8, BIT_CYCLES=4)
REQ-030 Reset and idle: rst=0 asserted mid-cycle -> sout=1, busy=0 and done=0 immediately, before the next clock edge.
REQ-031 Basic frame, no parity: start with din=8'hA5 -> sout bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy high for 40 cycles; done in cycle 41.
REQ-032 Parity build: din=8'hA5 -> parity bit 0 before stop, 44-cycle frame; din=8'h01 -> parity bit 1.
REQ-033 Ignored start: start with din=8'hFF pulsed at cycle 10 of an 8'hA5 frame -> serial output unchanged, no extra frame.
REQ-034 Abort: rst=0 at cycle 13 of a frame -> sout=1 at once, no done pulse; next start sends a full, clean frame.
REQ-035 Back-to-back: start held at 1 with din=8'h3C -> two identical frames separated by one idle cycle with done=1.
